// File: rtl/pe_pkg.sv
// Shared PE definitions: psum spad geometry defaults and the drain FSM state enum.
package pe_pkg;
  localparam int PSUM_DATA_W = 16;
  localparam int PSUM_ADDR_W = 3;
  localparam int PSUM_NUM    = 4;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_e;
endpackage

// File: rtl/psum_spad_drain_if.sv
// Spad read port + psum output link of the drain block. The spad clear-write port
// exists only when CLEAR_ON_READ_EN is defined.
interface psum_spad_drain_if #(
  parameter int DATA_W = pe_pkg::PSUM_DATA_W,
  parameter int ADDR_W = pe_pkg::PSUM_ADDR_W
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] psum_out;
  logic              psum_valid;
  logic              psum_ready;
  logic              psum_last;
`ifdef CLEAR_ON_READ_EN
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
`endif

  modport master (
    output rd_en, rd_addr, psum_out, psum_valid, psum_last,
`ifdef CLEAR_ON_READ_EN
    output wr_en, wr_addr, wr_data,
`endif
    input  rd_data, psum_ready
  );

  modport slave (
    input  rd_en, rd_addr, psum_out, psum_valid, psum_last,
`ifdef CLEAR_ON_READ_EN
    input  wr_en, wr_addr, wr_data,
`endif
    output rd_data, psum_ready
  );
endinterface

// File: rtl/psum_out_skid.sv
// 2-entry FIFO buffering spad read returns ({last, data}) in front of the output link.
module psum_out_skid #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   occ
);
  logic [W-1:0] mem [2];
  logic         wp, rp;
  logic         do_push, do_pop;

  // Push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp     <= 1'b0;
      rp     <= 1'b0;
      occ    <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop) rp <= ~rp;
      occ <= occ + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout = mem[rp];
endmodule

// File: rtl/psum_spad_drain.sv
// Drains psum spad entries 0..NUM_PSUM-1 in order onto a valid/ready link.
// CLEAR_ON_READ_EN: zero each entry in the spad as its read data returns.
module psum_spad_drain
  import pe_pkg::*;
#(
  parameter int DATA_W   = PSUM_DATA_W,
  parameter int ADDR_W   = PSUM_ADDR_W,
  parameter int NUM_PSUM = PSUM_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  psum_spad_drain_if.master   bus
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PSUM - 1);

  drain_state_e      state, nstate;
  logic [ADDR_W-1:0] rd_idx;
  logic              inflight, inf_last;
  logic [1:0]        occ;
  logic              pop, rd_en;
  logic [DATA_W:0]   head;

  assign pop   = bus.psum_valid && bus.psum_ready;
  // Credit: buffered + in-flight entries after this cycle's pop must stay below 2.
  assign rd_en = (state == RUN) &&
                 (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (start) nstate = RUN;
      RUN:   if (rd_en && (rd_idx == LAST_IDX)) nstate = FLUSH;
      // Leave once the buffer will be empty after this cycle's pop.
      FLUSH: if (!inflight && (occ == {1'b0, pop})) nstate = DONE;
      DONE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx   <= '0;
      inflight <= 1'b0;
      inf_last <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) inf_last <= (rd_idx == LAST_IDX);
      if (rd_en && (rd_idx != LAST_IDX)) rd_idx <= rd_idx + 1'b1;
      else if (state == DONE)            rd_idx <= '0;
    end
  end

  psum_out_skid #(.W(DATA_W + 1)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  ({inf_last, bus.rd_data}),
    .pop  (pop),
    .dout (head),
    .occ  (occ)
  );

  assign bus.rd_en      = rd_en;
  assign bus.rd_addr    = rd_idx;
  assign bus.psum_valid = (occ != 2'd0);
  assign bus.psum_out   = bus.psum_valid ? head[DATA_W-1:0] : '0;
  assign bus.psum_last  = bus.psum_valid && head[DATA_W];
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

`ifdef CLEAR_ON_READ_EN
  logic [ADDR_W-1:0] inf_addr;

  always_ff @(posedge clk) begin
    if (rst)        inf_addr <= '0;
    else if (rd_en) inf_addr <= rd_idx;
  end

  // The entry was read last cycle, so clearing it now cannot corrupt the read.
  assign bus.wr_en   = inflight;
  assign bus.wr_addr = inf_addr;
  assign bus.wr_data = '0;
`endif
endmodule

// File: tb/tb_psum_spad_drain.sv
// Bench for psum_spad_drain: spad model, per-scenario tasks, queue-based expected streams.
module tb_psum_spad_drain;
  logic clk, rst, start, busy, done;
  logic start1, busy1, done1;
  logic [15:0] rd_q, rd_q1;
  logic [15:0] spad [8];
  logic [15:0] load_val [8];
  logic [15:0] exp_v [4];
  logic        load_req;
  int n_chk, n_fail;

  psum_spad_drain_if #(.DATA_W(16), .ADDR_W(3)) bus ();
  psum_spad_drain_if #(.DATA_W(16), .ADDR_W(3)) bus1 ();

  psum_spad_drain #(.DATA_W(16), .ADDR_W(3), .NUM_PSUM(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus));
  psum_spad_drain #(.DATA_W(16), .ADDR_W(3), .NUM_PSUM(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.rd_data  = rd_q;
  assign bus1.rd_data = rd_q1;

  // Spad model: registered read, optional clear writes from the 4-entry DUT, bulk load.
  always @(posedge clk) begin
    if (bus.rd_en)  rd_q  <= spad[bus.rd_addr];
    if (bus1.rd_en) rd_q1 <= spad[bus1.rd_addr];
    if (load_req) begin
      for (int i = 0; i < 8; i++) spad[i] <= load_val[i];
    end
`ifdef CLEAR_ON_READ_EN
    else if (bus.wr_en) spad[bus.wr_addr] <= bus.wr_data;
`endif
  end

  logic [15:0] got_d [$];
  bit          got_l [$];
  int          got_cyc [$];
  int          wr_a [$];
  logic [15:0] wr_d [$];
  int done_cyc, n_done, busy_first, busy_last, busy_cnt, first_valid;
  int hold_viol, rden_3_8, rden_at9, post_act;

  task automatic load(input logic [15:0] a, b, c, d);
    load_val[0] = a; load_val[1] = b; load_val[2] = c; load_val[3] = d;
    for (int i = 4; i < 8; i++) load_val[i] = 16'h0;
    exp_v[0] = a; exp_v[1] = b; exp_v[2] = c; exp_v[3] = d;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Runs one drain from cycle 0 (start) and records what the link and spad port did.
  // mode: 0 ready high, 1 ready low in cycles 3..8, 2 ready on odd cycles, 3 random.
  task automatic drain(input int mode, input bit repulse);
    bit prev_stall;
    logic [15:0] prev_d;
    logic rdy;
    got_d.delete(); got_l.delete(); got_cyc.delete(); wr_a.delete(); wr_d.delete();
    done_cyc = -1; n_done = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
    first_valid = -1; hold_viol = 0; rden_3_8 = 0; rden_at9 = 0; post_act = 0;
    prev_stall = 1'b0; prev_d = 16'h0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (repulse && (cyc == 2 || cyc == 7));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(cyc >= 3 && cyc <= 8);
        2:       rdy = (cyc % 2 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.psum_ready = rdy;
      #1;
      if (bus.psum_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!bus.psum_valid || bus.psum_out !== prev_d)) hold_viol++;
      prev_stall = bus.psum_valid && !bus.psum_ready;
      prev_d     = bus.psum_out;
      if (bus.psum_valid && bus.psum_ready) begin
        got_d.push_back(bus.psum_out);
        got_l.push_back(bus.psum_last);
        got_cyc.push_back(cyc);
      end
      if (bus.rd_en && cyc >= 3 && cyc <= 8) rden_3_8++;
      if (bus.rd_en && cyc == 9) rden_at9 = 1;
`ifdef CLEAR_ON_READ_EN
      if (bus.wr_en) begin
        wr_a.push_back(int'(bus.wr_addr));
        wr_d.push_back(bus.wr_data);
      end
`endif
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc && (busy || bus.psum_valid || bus.rd_en)) post_act++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    start = 1'b0;
    bus.psum_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({busy, done, bus.rd_en, bus.rd_addr, bus.psum_valid, bus.psum_out, bus.psum_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b rd_en=%b rd_addr=%0d valid=%b out=%0d last=%b, expected all 0",
               busy, done, bus.rd_en, bus.rd_addr, bus.psum_valid, bus.psum_out, bus.psum_last);
    end
`ifdef CLEAR_ON_READ_EN
    n_chk++;
    if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.wr_en); end
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    load(16'd10, 16'd20, 16'd30, 16'd40);
    drain(0, 1'b0);
    n_chk++;
    if (got_d.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d expected 4", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_v[i % 4] || got_l[i] !== (i == 3) || got_cyc[i] != 3 + i) begin
        n_fail++;
        $display("FAIL basic_entry[%0d]: got data=%0d last=%b cycle=%0d expected data=%0d last=%b cycle=%0d",
                 i, got_d[i], got_l[i], got_cyc[i], exp_v[i % 4], (i == 3), 3 + i);
      end
    end
    n_chk++;
    if (done_cyc != 7 || n_done != 1) begin
      n_fail++; $display("FAIL basic_done: got cycle=%0d pulses=%0d expected cycle=7 pulses=1", done_cyc, n_done);
    end
    n_chk++;
    if (busy_first != 1 || busy_last != 7 || busy_cnt != 7) begin
      n_fail++; $display("FAIL basic_busy: got first=%0d last=%0d count=%0d expected 1 7 7", busy_first, busy_last, busy_cnt);
    end
`ifdef CLEAR_ON_READ_EN
    n_chk++;
    if (wr_a.size() != 4) begin n_fail++; $display("FAIL clear_wr_count: got %0d expected 4", wr_a.size()); end
    for (int i = 0; i < wr_a.size(); i++) begin
      n_chk++;
      if (wr_a[i] != i || wr_d[i] !== 16'h0) begin
        n_fail++; $display("FAIL clear_wr[%0d]: got addr=%0d data=%0d expected addr=%0d data=0", i, wr_a[i], wr_d[i], i);
      end
    end
`endif
  endtask

  task automatic test_backpressure;
    load(16'd10, 16'd20, 16'd30, 16'd40);
    drain(1, 1'b0);
    n_chk++;
    if (got_d.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_v[i % 4] || got_l[i] !== (i == 3) || got_cyc[i] != 9 + i) begin
        n_fail++;
        $display("FAIL bp_entry[%0d]: got data=%0d last=%b cycle=%0d expected data=%0d last=%b cycle=%0d",
                 i, got_d[i], got_l[i], got_cyc[i], exp_v[i % 4], (i == 3), 9 + i);
      end
    end
    n_chk++;
    if (rden_3_8 != 0 || rden_at9 != 1) begin
      n_fail++; $display("FAIL bp_rd_en: got stalled_reads=%0d read_at_9=%0d expected 0 and 1", rden_3_8, rden_at9);
    end
    n_chk++;
    if (hold_viol != 0 || first_valid != 3) begin
      n_fail++; $display("FAIL bp_hold: got violations=%0d first_valid=%0d expected 0 and 3", hold_viol, first_valid);
    end
    n_chk++;
    if (done_cyc != 13 || n_done != 1) begin
      n_fail++; $display("FAIL bp_done: got cycle=%0d pulses=%0d expected 13 and 1", done_cyc, n_done);
    end
  endtask

  task automatic test_toggle;
    load(16'd10, 16'd20, 16'd30, 16'd40);
    drain(2, 1'b0);
    n_chk++;
    if (got_d.size() != 4) begin n_fail++; $display("FAIL toggle_count: got %0d expected 4", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_v[i % 4] || got_l[i] !== (i == 3)) begin
        n_fail++; $display("FAIL toggle_entry[%0d]: got data=%0d last=%b expected data=%0d last=%b",
                           i, got_d[i], got_l[i], exp_v[i % 4], (i == 3));
      end
    end
    n_chk++;
    if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size()-1] + 1 || n_done != 1 || hold_viol != 0) begin
      n_fail++; $display("FAIL toggle_done: got done=%0d pulses=%0d hold_violations=%0d expected one pulse right after last handshake, no violations",
                         done_cyc, n_done, hold_viol);
    end
  endtask

  task automatic test_start_ignored;
    load(16'd10, 16'd20, 16'd30, 16'd40);
    drain(0, 1'b1);
    n_chk++;
    if (got_d.size() != 4 || n_done != 1 || done_cyc != 7 || post_act != 0) begin
      n_fail++; $display("FAIL restart_ignored: got entries=%0d pulses=%0d done=%0d post_activity=%0d expected 4 1 7 0",
                         got_d.size(), n_done, done_cyc, post_act);
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_v[i % 4]) begin
        n_fail++; $display("FAIL restart_entry[%0d]: got %0d expected %0d", i, got_d[i], exp_v[i % 4]);
      end
    end
  endtask

  task automatic test_rst_midrun;
    int hs, nd, nb;
    hs = 0; nd = 0; nb = 0;
    load(16'd10, 16'd20, 16'd30, 16'd40);
    for (int cyc = 0; cyc <= 4; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      bus.psum_ready = (cyc != 4);
      rst = (cyc == 4);
      #1;
      if (bus.psum_valid && bus.psum_ready) hs++;
    end
    @(negedge clk);
    rst = 1'b0; bus.psum_ready = 1'b1;
    #1;
    n_chk++;
    if (hs != 1) begin n_fail++; $display("FAIL rst_delivered: got %0d expected 1", hs); end
    n_chk++;
    if ({busy, done, bus.rd_en, bus.rd_addr, bus.psum_valid, bus.psum_out, bus.psum_last} !== '0) begin
      n_fail++; $display("FAIL rst_outputs: got busy=%b done=%b rd_en=%b rd_addr=%0d valid=%b out=%0d last=%b, expected all 0",
                         busy, done, bus.rd_en, bus.rd_addr, bus.psum_valid, bus.psum_out, bus.psum_last);
    end
    repeat (6) begin
      @(negedge clk); #1;
      if (done) nd++;
      if (busy || bus.psum_valid) nb++;
    end
    n_chk++;
    if (nd != 0 || nb != 0) begin n_fail++; $display("FAIL rst_quiet: got done=%0d active=%0d expected 0 0", nd, nb); end
    bus.psum_ready = 1'b0;
    load(16'd10, 16'd20, 16'd30, 16'd40);
    drain(0, 1'b0);
    n_chk++;
    if (got_d.size() != 4 || done_cyc != 7) begin
      n_fail++; $display("FAIL rst_redrain: got entries=%0d done=%0d expected 4 7", got_d.size(), done_cyc);
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp_v[i % 4]) begin
        n_fail++; $display("FAIL rst_redrain_entry[%0d]: got %0d expected %0d", i, got_d[i], exp_v[i % 4]);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      drain(3, 1'b0);
      n_chk++;
      if (got_d.size() != 4 || n_done != 1 || hold_viol != 0) begin
        n_fail++; $display("FAIL rand%0d_summary: got entries=%0d pulses=%0d hold_violations=%0d expected 4 1 0",
                           it, got_d.size(), n_done, hold_viol);
      end
      for (int i = 0; i < got_d.size(); i++) begin
        n_chk++;
        if (got_d[i] !== exp_v[i % 4] || got_l[i] !== (i == 3)) begin
          n_fail++; $display("FAIL rand%0d_entry[%0d]: got data=%0h last=%b expected data=%0h last=%b",
                             it, i, got_d[i], got_l[i], exp_v[i % 4], (i == 3));
        end
      end
      n_chk++;
      if (got_cyc.size() == 0 || done_cyc != got_cyc[got_cyc.size()-1] + 1) begin
        n_fail++; $display("FAIL rand%0d_done: got %0d expected one cycle after last handshake", it, done_cyc);
      end
    end
  endtask

  // Second drain sees zeros when entries are cleared on read, the same data otherwise.
  task automatic test_back_to_back;
    logic [15:0] exp2 [4];
    load(16'd11, 16'd22, 16'd33, 16'd44);
    drain(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
`ifdef CLEAR_ON_READ_EN
      exp2[i] = 16'h0;
`else
      exp2[i] = exp_v[i];
`endif
    end
    drain(0, 1'b0);
    n_chk++;
    if (got_d.size() != 4 || done_cyc != 7) begin
      n_fail++; $display("FAIL b2b_count: got entries=%0d done=%0d expected 4 7", got_d.size(), done_cyc);
    end
    for (int i = 0; i < got_d.size(); i++) begin
      n_chk++;
      if (got_d[i] !== exp2[i % 4]) begin
        n_fail++; $display("FAIL b2b_entry[%0d]: got %0d expected %0d", i, got_d[i], exp2[i % 4]);
      end
    end
  endtask

  task automatic test_single;
    int hs, hs_cyc, dcyc;
    logic [15:0] hs_d;
    logic hs_l;
    hs = 0; hs_cyc = -1; dcyc = -1; hs_d = 16'h0; hs_l = 1'b0;
    load(16'd77, 16'd88, 16'd99, 16'd66);
    bus1.psum_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      start1 = (cyc == 0);
      #1;
      if (bus1.psum_valid) begin hs++; hs_cyc = cyc; hs_d = bus1.psum_out; hs_l = bus1.psum_last; end
      if (done1 && dcyc < 0) dcyc = cyc;
    end
    start1 = 1'b0;
    n_chk++;
    if (hs != 1 || hs_cyc != 3 || hs_d !== exp_v[0] || hs_l !== 1'b1) begin
      n_fail++; $display("FAIL single_entry: got count=%0d cycle=%0d data=%0d last=%b expected 1 3 %0d 1",
                         hs, hs_cyc, hs_d, hs_l, exp_v[0]);
    end
    n_chk++;
    if (dcyc != 4) begin n_fail++; $display("FAIL single_done: got %0d expected 4", dcyc); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; load_req = 1'b0;
    bus.psum_ready = 1'b0; bus1.psum_ready = 1'b0;
    for (int i = 0; i < 8; i++) load_val[i] = 16'h0;
    test_reset;
    test_basic;
    test_backpressure;
    test_toggle;
    test_start_ignored;
    test_rst_midrun;
    test_random;
    test_back_to_back;
    test_single;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_spad_drain.md
# psum_spad_drain

Read-side controller for the PE partial-sum scratchpad. The compute path writes psums into the spad using the address counter in PE_control. After compute finishes, this block reads entries 0..NUM_PSUM-1 back in order and streams them out of the PE over a valid/ready handshake. It sits between the psum spad read port and the PE's psum output link, and stalls its spad reads under downstream backpressure without losing data.

## Interface
- DATA_W, 16: psum width in bits.
- ADDR_W, 3: spad address width.
- NUM_PSUM, 4: number of entries drained per run, 1..2^ADDR_W. This matches the compute-side wrap at 4.
- clk  in  1: single clock; all logic is on posedge.
- rst  in  1: synchronous, active-high reset.
- start  in  1: one-cycle request to begin a drain; ignored unless the block is idle.
- busy  out  1: high from the cycle after an accepted start until done.
- done  out  1: one-cycle pulse after the last psum handshake.
- rd_en  out  1: spad read strobe.
- rd_addr  out  ADDR_W: spad read address.
- rd_data  in  DATA_W: spad read data, valid exactly 1 cycle after rd_en.
- psum_out  out  DATA_W: output psum.
- psum_valid  out  1: psum_out is valid.
- psum_ready  in  1: downstream accepts psum_out.
- psum_last  out  1: qualifies the entry NUM_PSUM-1.
- wr_en, wr_addr[ADDR_W], wr_data[DATA_W]  out: spad write port. Present only with CLEAR_ON_READ_EN.

## Operation
- FSM states:
  - IDLE: start → RUN.
  - RUN: the read index steps 0..NUM_PSUM-1. When all reads have been issued, go to FLUSH.
  - FLUSH: wait until the buffer and in-flight slot are both empty, then go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- Read issue rule:
  - rd_en = RUN && (occupancy + inflight − pop) < 2.
  - pop = psum_valid && psum_ready.
  - rd_addr = current read index. The index increments only on an issued read.
- Returned rd_data is always written into a 2-entry output buffer, one cycle after its rd_en. The credit rule guarantees the buffer is never overrun.
- psum_last travels with each entry: it is set when that entry's read index equals NUM_PSUM-1.
- Output behaviour:
  - psum_valid = buffer not empty.
  - psum_out and psum_last come from the buffer head.
  - Data is held stable while valid && !ready.
- Reset values: state IDLE, read index 0, buffer empty, inflight 0. All outputs are 0: busy, done, rd_en, rd_addr, psum_valid, psum_out, psum_last, wr_en.
- Boundary conditions:
  - start while busy: ignored, no effect.
  - start in the DONE cycle: ignored.
  - NUM_PSUM=1: a single entry with psum_last=1.
  - Read-index wrap: the index never exceeds NUM_PSUM-1. It returns to 0 on entering IDLE.
  - rst mid-run: immediate return to IDLE, buffer flushed, in-flight data dropped, no done pulse.
  - Simultaneous buffer push and pop: occupancy is unchanged and order is preserved.

## Timing
- start sampled at cycle 0 → rd_en with addr 0 at cycle 1 → data captured at the end of cycle 2 → psum_valid first high in cycle 3.
- With psum_ready held high:
  - Throughput is 1 psum per cycle.
  - Entries appear in cycles 3..3+NUM_PSUM-1.
  - done pulses in cycle 3+NUM_PSUM.
- busy is high from cycle 1 through the done cycle inclusive.
- Backpressure:
  - Buffer full and no pop → rd_en is held low.
  - Reads resume in the same cycle that a pop frees a credit.

## Configuration
- CLEAR_ON_READ_EN defined:
  - Each entry read is zeroed in the spad, so the next accumulation pass starts from 0.
  - The write happens in the same cycle that entry's rd_data returns: wr_en=1, wr_addr = that entry's address, wr_data=0.
  - Read-before-write is guaranteed because the read occurred one cycle earlier.
- CLEAR_ON_READ_EN undefined: the wr_* ports and their logic are absent, and the spad contents are untouched.

## Structure
- A shared package pe_pkg holds:
  - the drain FSM state enum (IDLE, RUN, FLUSH, DONE);
  - default PSUM DATA_W/ADDR_W constants, shared with PE_control.
- Sub-module psum_out_skid: a 2-entry FIFO with push/pop/occupancy, carrying {psum_last, data}.

## Test plan
- NUM_PSUM=4, spad = {10,20,30,40}, ready always high, start at cycle 0 → psum_out 10,20,30,40 in cycles 3–6; psum_last only on 40; done at cycle 7.
- Same setup, ready low for cycles 3–8 → rd_en drops after 2 entries are buffered; psum_out holds 10 stable; full order 10,20,30,40 delivered once ready rises; no duplicates or losses.
- Ready toggling every cycle → every psum is delivered exactly once, in order; done follows the handshake of 40.
- start re-pulsed at cycle 2 and again in the done cycle → ignored; exactly one run of 4 entries.
- rst asserted at cycle 4 with 1 entry delivered → next cycle all outputs are 0 and state is IDLE; no done; a new start then drains entries 0..3 from the beginning.
- CLEAR_ON_READ_EN defined → wr_en pulses with addresses 0,1,2,3 and wr_data=0; a second drain outputs 0,0,0,0.
